// File: rtl/uart_core_if.sv
// Core-bus access channel for the memory-mapped UART: strobe, direction, address
// and data out from the CPU; registered read data and a one-cycle ready back.
`timescale 1ns/1ps

interface uart_core_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, output we, output address, output write_data,
                  input  read_data, input ready);
  modport slave  (input  cs, input  we, input  address, input  write_data,
                  output read_data, output ready);
endinterface

// File: rtl/uart_core.sv
// 8N1 UART with a memory-mapped register file: an RX deserialiser feeding a one-byte
// holding register with sticky overrun/framing flags, and a TX serialiser.
`timescale 1ns/1ps

module uart_core #(
  parameter logic [15:0] DEFAULT_BIT_RATE = 16'd217
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_core_if.slave  bus,
  input  logic        rxd,
  output logic        txd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Bus side: accepted request is latched so its side effects land in the ready cycle.
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_acc_we;
  logic [7:0]  r_acc_addr;
  logic [15:0] r_acc_wdata;
  logic        w_accept;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  logic        w_wr_tx, w_wr_rate, w_wr_clr, w_rd_rx;

  logic [15:0] r_bit_rate;
  logic        r_rx_valid, r_overrun, r_frame_err;
  logic [7:0]  r_rx_data;

  state_t      r_tx_state, w_tx_state_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_rate, w_tx_rate_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic [7:0]  r_tx_shift, w_tx_shift_n;
  logic        r_txd, w_txd_n, w_tx_end, w_tx_busy;

  state_t      r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_rate, w_rx_rate_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [7:0]  r_rx_shift, w_rx_shift_n;
  logic        r_rx_brk, w_rx_brk_n;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_rx_done, w_rx_ferr, w_rx_end;

  assign w_accept       = bus.cs && !r_ready;
  assign w_unused_wdata = ^bus.write_data[31:16];
  assign bus.ready      = r_ready;
  assign bus.read_data  = r_rdata;
  assign txd            = r_txd;

  assign w_wr_tx   = r_ready &&  r_acc_we && (r_acc_addr == 8'h02);
  assign w_wr_rate = r_ready &&  r_acc_we && (r_acc_addr == 8'h03);
  assign w_wr_clr  = r_ready &&  r_acc_we && (r_acc_addr == 8'h04);
  assign w_rd_rx   = r_ready && !r_acc_we && (r_acc_addr == 8'h01);
  assign w_tx_busy = (r_tx_state != S_IDLE);

  // Read multiplexer evaluated in the accept cycle
  always_comb begin
    w_rd_mux = 32'd0;
    case (bus.address)
      8'h00:   w_rd_mux = {28'd0, r_frame_err, r_overrun, w_tx_busy, r_rx_valid};
      8'h01:   w_rd_mux = {24'd0, r_rx_data};
      8'h03:   w_rd_mux = {16'd0, r_bit_rate};
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Bus handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_rdata     <= 32'd0;
      r_acc_we    <= 1'b0;
      r_acc_addr  <= 8'd0;
      r_acc_wdata <= 16'd0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) begin
        r_acc_we    <= bus.we;
        r_acc_addr  <= bus.address;
        r_acc_wdata <= bus.write_data[15:0];
        r_rdata     <= bus.we ? 32'd0 : w_rd_mux;
      end else begin
        r_rdata <= 32'd0;
      end
    end
  end

  // Control/status registers; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_rate  <= DEFAULT_BIT_RATE;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_data   <= 8'd0;
    end else begin
      if (w_wr_rate) begin
        r_bit_rate <= (r_acc_wdata < 16'd4) ? 16'd4 : r_acc_wdata;
      end
      if (w_rx_done && (!r_rx_valid || w_rd_rx)) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !w_rd_rx) begin
        r_overrun <= 1'b1;
      end else if (w_wr_clr && r_acc_wdata[2]) begin
        r_overrun <= 1'b0;
      end
      if (w_rx_ferr) begin
        r_frame_err <= 1'b1;
      end else if (w_wr_clr && r_acc_wdata[3]) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign w_tx_end = (r_tx_cnt == r_tx_rate - 16'd1);

  // TX next state; txd is registered from the next-state view so it moves on bit boundaries
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt + 16'd1;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_rate_n  = r_tx_rate;
    w_txd_n      = 1'b1;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_n = 16'd0;
        if (w_wr_tx) begin
          w_tx_state_n = S_START;
          w_tx_rate_n  = r_bit_rate;
          w_tx_shift_n = r_acc_wdata[7:0];
          w_txd_n      = 1'b0;
        end else begin
          w_txd_n = 1'b1;
        end
      end
      S_START: begin
        w_txd_n = 1'b0;
        if (w_tx_end) begin
          w_tx_state_n = S_DATA;
          w_tx_cnt_n   = 16'd0;
          w_tx_bit_n   = 3'd0;
          w_txd_n      = r_tx_shift[0];
        end else begin
          w_txd_n = 1'b0;
        end
      end
      S_DATA: begin
        w_txd_n = r_tx_shift[0];
        if (w_tx_end) begin
          w_tx_cnt_n = 16'd0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = S_STOP;
            w_txd_n      = 1'b1;
          end else begin
            w_tx_bit_n   = r_tx_bit + 3'd1;
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_txd_n      = r_tx_shift[1];
          end
        end else begin
          w_txd_n = r_tx_shift[0];
        end
      end
      S_STOP: begin
        w_txd_n = 1'b1;
        if (w_tx_end) begin
          w_tx_state_n = S_IDLE;
          w_tx_cnt_n   = 16'd0;
        end else begin
          w_tx_state_n = S_STOP;
        end
      end
      default: begin
        w_tx_state_n = S_IDLE;
        w_tx_cnt_n   = 16'd0;
      end
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx_rate  <= DEFAULT_BIT_RATE;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_rate  <= w_tx_rate_n;
      r_txd      <= w_txd_n;
    end
  end

  assign w_rx_end = (r_rx_cnt == r_rx_rate - 16'd1);

  // RX next state; r_rx_brk holds STOP after a bad stop bit until the line returns high
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + 16'd1;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_rate_n  = r_rx_rate;
    w_rx_brk_n   = r_rx_brk;
    w_rx_done    = 1'b0;
    w_rx_ferr    = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_n = 16'd0;
        w_rx_brk_n = 1'b0;
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_n = S_START;
          w_rx_rate_n  = r_bit_rate;
        end else begin
          w_rx_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (r_rx_cnt == {1'b0, r_rx_rate[15:1]}) begin
          w_rx_cnt_n   = 16'd0;
          w_rx_bit_n   = 3'd0;
          w_rx_state_n = r_rx_s2 ? S_IDLE : S_DATA;
        end else begin
          w_rx_state_n = S_START;
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_n   = 16'd0;
          w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_bit_n   = r_rx_bit + 3'd1;
          w_rx_state_n = (r_rx_bit == 3'd7) ? S_STOP : S_DATA;
        end else begin
          w_rx_state_n = S_DATA;
        end
      end
      S_STOP: begin
        if (r_rx_brk) begin
          w_rx_cnt_n   = r_rx_cnt;
          w_rx_state_n = r_rx_s2 ? S_IDLE : S_STOP;
        end else if (w_rx_end) begin
          if (r_rx_s2) begin
            w_rx_done    = 1'b1;
            w_rx_state_n = S_IDLE;
          end else begin
            w_rx_ferr  = 1'b1;
            w_rx_brk_n = 1'b1;
          end
        end else begin
          w_rx_state_n = S_STOP;
        end
      end
      default: begin
        w_rx_state_n = S_IDLE;
        w_rx_cnt_n   = 16'd0;
      end
    endcase
  end

  // RX synchroniser, edge history and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_rate  <= DEFAULT_BIT_RATE;
      r_rx_brk   <= 1'b0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_rate  <= w_rx_rate_n;
      r_rx_brk   <= w_rx_brk_n;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: register-map vector table, exact TX waveform,
// RX scenarios (overrun, framing, glitch), async reset, and a randomized scoreboard phase.
`timescale 1ns/1ps

module tb_uart_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  uart_core_if bus ();

  uart_core #(.DEFAULT_BIT_RATE(16'd217)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  // reference-model state for the randomized phase
  logic       mdl_valid, mdl_ovr, mdl_ferr;
  logic [7:0] mdl_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.cs = 1'b1; bus.we = w; bus.address = a; bus.write_data = d;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.ready !== 1'b1 && lat < 4);
    rd = bus.read_data;
    bus.cs = 1'b0; bus.we = 1'b0;
    chk("ready_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("ready_pulse", 32'(bus.ready), 32'd0);
    chk("rdata_idle", bus.read_data, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    access(1'b0, a, 32'd0, rd);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    access(1'b1, a, d, rd);
  endtask

  task automatic rx_send(input logic [7:0] b, input int r, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rxd = fr[k];
      repeat (r - 1) @(negedge clk);
    end
  endtask

  // Independent UART receiver on txd: find the start bit, then sample each bit mid-cell
  task automatic tx_decode(input int r, input logic [7:0] exp);
    logic [7:0] got;
    int w;
    w = 0;
    while (txd !== 1'b0 && w < 3 * r) begin
      @(negedge clk);
      w++;
    end
    chk("tx_start_seen", 32'(txd), 32'd0);
    repeat (r / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (r) @(negedge clk);
      got[k] = txd;
    end
    repeat (r) @(negedge clk);
    chk("tx_stop_bit", 32'(txd), 32'd1);
    chk("tx_decoded", {24'd0, got}, {24'd0, exp});
    repeat (r + 2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          lows, rw, eff, nb;

    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'd0; bus.write_data = 32'd0;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 8'h03, 32'h0,        32'd217};
    vecs[2]  = '{1'b0, 8'h01, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 8'h07, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 8'h20, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 8'h03, 32'h2,        32'h0};
    vecs[7]  = '{1'b0, 8'h03, 32'h0,        32'h4};
    vecs[8]  = '{1'b1, 8'h03, 32'hABCD_0010, 32'h0};
    vecs[9]  = '{1'b0, 8'h03, 32'h0,        32'h10};
    vecs[10] = '{1'b1, 8'h03, 32'h8,        32'h0};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_rdata", bus.read_data, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      if (!vecs[i].we) chk($sformatf("vec%0d_read", i), rd, vecs[i].exp);
    end
    rd_chk("rate_after_vec", 8'h03, 32'd8);

    // exact TX waveform for 0xA5 at 8 clk/bit, with a dropped write while busy
    wr(8'h02, 32'hA5);
    fork
      begin
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 80; i++) begin
          chk($sformatf("tx_cyc%0d", i), 32'(txd), 32'(fr[i / 8]));
          @(negedge clk);
        end
      end
      begin
        repeat (5) @(negedge clk);
        wr(8'h02, 32'h3C);
        rd_chk("status_busy", 8'h00, 32'h2);
      end
    join
    rd_chk("status_tx_done", 8'h00, 32'h0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("tx_dropped_stays_idle", 32'(lows), 32'd0);

    // RX single byte
    rx_send(8'h5A, 8, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("rx_status_valid", 8'h00, 32'h1);
    rd_chk("rx_data_5a", 8'h01, 32'h5A);
    rd_chk("rx_status_clear", 8'h00, 32'h0);

    // overrun
    rx_send(8'h11, 8, 1'b1);
    rx_send(8'h22, 8, 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("ovr_status", 8'h00, 32'h5);
    rd_chk("ovr_data_kept", 8'h01, 32'h11);
    rd_chk("ovr_after_read", 8'h00, 32'h4);
    wr(8'h04, 32'h4);
    rd_chk("ovr_cleared", 8'h00, 32'h0);

    // framing error: stop bit low, line held low, then released
    rx_send(8'h3C, 8, 1'b0);
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("ferr_status", 8'h00, 32'h8);
    rd_chk("ferr_data_kept", 8'h01, 32'h11);
    wr(8'h04, 32'h8);
    rd_chk("ferr_cleared", 8'h00, 32'h0);

    // 3-cycle glitch is not a start bit
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    rd_chk("glitch_ignored", 8'h00, 32'h0);

    // async reset in the middle of a TX start bit
    wr(8'h02, 32'h00);
    repeat (2) @(negedge clk);
    chk("midtx_start_low", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midtx_reset_txd", 32'(txd), 32'd1);
    chk("midtx_reset_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("reset_rate_restored", 8'h03, 32'd217);
    rd_chk("reset_status", 8'h00, 32'h0);

    // randomized phase against a scoreboard model
    mdl_valid = 1'b0; mdl_ovr = 1'b0; mdl_ferr = 1'b0; mdl_byte = 8'h00;
    for (int it = 0; it < 10; it++) begin
      rw  = $urandom_range(0, 14);
      eff = (rw < 4) ? 4 : rw;
      wr(8'h03, 32'(rw));
      rd_chk("rnd_rate", 8'h03, 32'(eff));
      nb = $urandom_range(0, 2);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        rx_send(b, eff, 1'b1);
        if (!mdl_valid) begin
          mdl_valid = 1'b1;
          mdl_byte  = b;
        end else begin
          mdl_ovr = 1'b1;
        end
      end
      repeat (6) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        wr(8'h02, {24'd0, b});
        tx_decode(eff, b);
      end
      rd_chk("rnd_status", 8'h00, {28'd0, mdl_ferr, mdl_ovr, 1'b0, mdl_valid});
      rd_chk("rnd_rxdata", 8'h01, {24'd0, mdl_byte});
      mdl_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        wr(8'h04, 32'hC);
        mdl_ovr = 1'b0;
        mdl_ferr = 1'b0;
      end
      rd_chk("rnd_status_after", 8'h00, {28'd0, mdl_ferr, mdl_ovr, 1'b0, mdl_valid});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
